// File: rtl/vec_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_pkg
// Purpose  : Shared constants, state enumeration and lane-select helper for
//            the vector memory-stage sequencer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vec_mem_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int VEC_W  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Extract word lane 'idx' from a full vector.
    function automatic logic [LANE_W-1:0] lane_sel(
        input logic [VEC_W-1:0]         vec,
        input logic [$clog2(LANES)-1:0] idx
    );
        return vec[idx*LANE_W +: LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer_if
// Purpose  : Narrow req/ack data-memory port used by the vector sequencer.
// Ports    : mem_req/mem_we/mem_addr/mem_wdata  sequencer -> memory
//            mem_rdata/mem_ack                  memory -> sequencer
//            modport master = sequencer side, modport slave = memory side
// Revision : 1.0 - initial release
// ============================================================================
interface vec_mem_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int LANE_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANE_W-1:0] mem_wdata;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/vec_mem_sequencer_lane_gather.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_gather
// Purpose  : Holds the assembled load vector; one word lane is written per
//            accepted load beat, all other lanes keep their value.
// Ports    : clk, reset   clock / synchronous active-high reset
//            we, idx      lane write enable and lane index
//            wdata        lane write data
//            rdata        full assembled vector
// Revision : 1.0 - initial release
// ============================================================================
module vec_lane_gather #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    we,
    input  wire logic [IDX_W-1:0]        idx,
    input  wire logic [LANE_W-1:0]       wdata,
    output logic [LANES*LANE_W-1:0]      rdata
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] r_lane;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_lane <= '0;
            end else if (we && (idx == IDX_W'(g))) begin
                r_lane <= wdata;
            end
        end

        assign rdata[g*LANE_W +: LANE_W] = r_lane;
    end

endmodule
`default_nettype wire

// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer
// Purpose  : Memory-stage controller that splits a 256-bit vector load/store
//            into LANES word beats on a narrow req/ack port, stalling the
//            pipeline until all beats complete.
// Ports    : clk, reset              clock / synchronous active-high reset
//            MemWriteM, MemtoRegM    store / load request (store wins)
//            ALUResultM, WriteDataM  base byte address / store vector
//            mem                     memory port (master modport)
//            stall_m                 pipeline freeze
//            ReadDataM               assembled load vector
//            done_m                  one-cycle completion pulse
//            err_m                   ack-timeout flag (VEC_MEM_TIMEOUT_EN only)
// Macro    : VEC_MEM_TIMEOUT_EN enables the ack watchdog and err_m output.
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_sequencer #(
    parameter int LANES          = 8,
    parameter int LANE_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          MemWriteM,
    input  wire logic                          MemtoRegM,
    input  wire logic [vec_mem_pkg::VEC_W-1:0] ALUResultM,
    input  wire logic [vec_mem_pkg::VEC_W-1:0] WriteDataM,
    vec_mem_sequencer_if.master                mem,
    output logic                               stall_m,
    output logic [vec_mem_pkg::VEC_W-1:0]      ReadDataM,
    output logic                               done_m
`ifdef VEC_MEM_TIMEOUT_EN
    ,
    output logic                               err_m
`endif
);
    import vec_mem_pkg::*;

    localparam int                BEAT_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [1:0]        ST_IDLE    = IDLE;
    localparam logic [1:0]        ST_BUSY    = BUSY;
    localparam logic [1:0]        ST_DONE    = DONE;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(LANE_W / 8);

    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [VEC_W-1:0]  r_data;
    logic              w_req;
    logic              w_ack;
    logic              w_gather_we;
    logic              w_unused;

    assign w_req = MemWriteM | MemtoRegM;
    // Ack only counts while a beat is actually being requested.
    assign w_ack = (r_state == ST_BUSY) & mem.mem_req & mem.mem_ack;
    // Store beats must never disturb the load vector.
    assign w_gather_we = w_ack & ~mem.mem_we;
    // Only the low ADDR_W bits of ALUResultM carry the address.
    assign w_unused = &{1'b0, ALUResultM[VEC_W-1:ADDR_W]};

    assign stall_m = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
    assign done_m  = (r_state == ST_DONE);

`ifdef VEC_MEM_TIMEOUT_EN
    localparam int                WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              w_timeout;

    // Fires on the TIMEOUT_CYCLES-th consecutive BUSY cycle without ack.
    assign w_timeout = (r_state == ST_BUSY) && !w_ack && (r_wdog == WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
            err_m  <= 1'b0;
        end else begin
            if (((r_state == ST_IDLE) && w_req) || w_ack) begin
                r_wdog <= '0;
            end else if (r_state == ST_BUSY) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_timeout) begin
                err_m <= 1'b1;
            end else if (r_state == ST_DONE) begin
                err_m <= 1'b0;
            end
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_beat        <= '0;
            r_data        <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // MemWriteM alone selects the direction, so a
                        // simultaneous load request is simply dropped.
                        r_state       <= ST_BUSY;
                        r_beat        <= '0;
                        r_data        <= WriteDataM;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= MemWriteM;
                        mem.mem_addr  <= ALUResultM[ADDR_W-1:0];
                        mem.mem_wdata <= lane_sel(WriteDataM, '0);
                    end
                end
                ST_BUSY: begin
                    if (w_ack) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state     <= ST_DONE;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                        end else begin
                            r_beat        <= r_beat + 1'b1;
                            // Address wraps naturally at 2^ADDR_W.
                            mem.mem_addr  <= mem.mem_addr + BEAT_BYTES;
                            mem.mem_wdata <= lane_sel(r_data, r_beat + 1'b1);
                        end
                    end
`ifdef VEC_MEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state     <= ST_DONE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end
`endif
                end
                ST_DONE: begin
                    // Requests are ignored here so the retiring instruction
                    // cannot re-trigger.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    vec_lane_gather #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .IDX_W  (BEAT_W)
    ) u_gather (
        .clk   (clk),
        .reset (reset),
        .we    (w_gather_we),
        .idx   (r_beat),
        .wdata (mem.mem_rdata),
        .rdata (ReadDataM)
    );

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Purpose  : Self-checking bench for vec_mem_sequencer with a word-addressed
//            memory model and transaction-level expectations.
// Macro    : VEC_MEM_TIMEOUT_EN adds err_m checks and a watchdog scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemWriteM;
    logic         MemtoRegM;
    logic [255:0] ALUResultM;
    logic [255:0] WriteDataM;
    logic         stall_m;
    logic [255:0] ReadDataM;
    logic         done_m;
`ifdef VEC_MEM_TIMEOUT_EN
    logic         err_m;
`endif

    vec_mem_sequencer_if #(.ADDR_W(32), .LANE_W(32)) mif ();

    vec_mem_sequencer #(
        .LANES          (8),
        .LANE_W         (32),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem        (mif),
        .stall_m    (stall_m),
        .ReadDataM  (ReadDataM),
        .done_m     (done_m)
`ifdef VEC_MEM_TIMEOUT_EN
        ,
        .err_m      (err_m)
`endif
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [255:0]  exp_rd;
    logic [31:0]   mem_m [logic [31:0]];
    logic [31:0]   addr_q [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string name, input bit exp);
`ifdef VEC_MEM_TIMEOUT_EN
        chk(name, {255'd0, err_m}, {255'd0, exp});
`endif
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem_m.exists(a)) mem_m[a] = $urandom;
        return mem_m[a];
    endfunction

    // Outputs expected whenever the sequencer is not working on a vector.
    task automatic check_quiet(input string tag);
        chk({tag, "_req"},   {255'd0, mif.mem_req}, 256'd0);
        chk({tag, "_stall"}, {255'd0, stall_m},     256'd0);
        chk({tag, "_done"},  {255'd0, done_m},      256'd0);
        chk({tag, "_rdata"}, ReadDataM,             exp_rd);
        chk_err({tag, "_err"}, 1'b0);
    endtask

    // One complete vector operation, driven and checked cycle by cycle.
    // Called right after a negedge. abort_beat: assert reset on that beat.
    // stuck_beat: withhold ack forever on that beat (watchdog scenario).
    task automatic run_vec(input bit st, input bit ld, input logic [31:0] base,
                           input logic [255:0] wd, input int dmin, input int dmax,
                           input int abort_beat, input int stuck_beat, output int stalls);
        bit          is_st;
        bit          timed_out;
        logic [31:0] a;
        logic [31:0] rv;
        int          d;

        is_st     = st;
        timed_out = 1'b0;
        stalls    = 0;
        addr_q.delete();

        MemWriteM     = st;
        MemtoRegM     = ld;
        ALUResultM    = {rand256() >> 32, base};
        WriteDataM    = wd;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = $urandom;
        #1;
        chk("req_stall", {255'd0, stall_m}, {255'd0, (st | ld)});
        chk("req_memreq", {255'd0, mif.mem_req}, 256'd0);
        if (stall_m) stalls++;

        for (int k = 0; k < 8; k++) begin
            a = base + 32'(4 * k);
            d = (k == stuck_beat) ? TO - 1 : int'($urandom_range(dmin, dmax));
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                chk("busy_req",   {255'd0, mif.mem_req}, 256'd1);
                chk("busy_we",    {255'd0, mif.mem_we},  {255'd0, is_st});
                chk("busy_addr",  {224'd0, mif.mem_addr},  {224'd0, a});
                chk("busy_wdata", {224'd0, mif.mem_wdata}, {224'd0, wd[k*32 +: 32]});
                chk("busy_stall", {255'd0, stall_m}, 256'd1);
                chk("busy_done",  {255'd0, done_m},  256'd0);
                chk("busy_rdata", ReadDataM, exp_rd);
                chk_err("busy_err", 1'b0);
                if (stall_m) stalls++;

                // Operands are latched, so garbage on the inputs must not matter.
                MemWriteM  = 1'($urandom);
                MemtoRegM  = 1'($urandom);
                ALUResultM = rand256();
                WriteDataM = rand256();

                if (k == abort_beat && w == 0) begin
                    reset       = 1'b1;
                    MemWriteM   = 1'b0;
                    MemtoRegM   = 1'b0;
                    mif.mem_ack = 1'b0;
                    @(negedge clk);
                    exp_rd = '0;
                    check_quiet("abort");
                    chk("abort_addr", {224'd0, mif.mem_addr}, 256'd0);
                    reset = 1'b0;
                    return;
                end

                mif.mem_ack = (k != stuck_beat) && (w == d);
                if (mif.mem_ack) begin
                    addr_q.push_back(a);
                    if (is_st) begin
                        mem_m[a]      = wd[k*32 +: 32];
                        mif.mem_rdata = $urandom;
                    end else begin
                        rv                 = mem_read(a);
                        mif.mem_rdata      = rv;
                        exp_rd[k*32 +: 32] = rv;
                    end
                end else begin
                    mif.mem_rdata = $urandom;
                end
            end
            if (k == stuck_beat) begin
                timed_out = 1'b1;
                break;
            end
        end

        @(negedge clk);
        chk("done_req",   {255'd0, mif.mem_req}, 256'd0);
        chk("done_pulse", {255'd0, done_m},  256'd1);
        chk("done_stall", {255'd0, stall_m}, 256'd0);
        chk("done_rdata", ReadDataM, exp_rd);
        chk_err("done_err", timed_out);
        mif.mem_ack = 1'b0;
        MemWriteM   = 1'b0;
        MemtoRegM   = 1'b0;

        @(negedge clk);
        check_quiet("idle_after");
    endtask

    logic [31:0]  wrap_exp [8];
    logic [255:0] snap;
    int           st_cnt;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset         = 1'b1;
        MemWriteM     = 1'b0;
        MemtoRegM     = 1'b0;
        ALUResultM    = '0;
        WriteDataM    = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        exp_rd        = '0;
        wrap_exp      = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4,
                          32'h8, 32'hC, 32'h10, 32'h14};

        repeat (3) @(negedge clk);
        check_quiet("reset");
        chk("reset_we",    {255'd0, mif.mem_we},   256'd0);
        chk("reset_addr",  {224'd0, mif.mem_addr}, 256'd0);
        chk("reset_wdata", {224'd0, mif.mem_wdata}, 256'd0);
        reset = 1'b0;
        @(negedge clk);

        // Store, ack tied high: 9 stall cycles, addresses 0x100..0x11C.
        run_vec(1'b1, 1'b0, 32'h100,
                256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111,
                0, 0, -1, -1, st_cnt);
        chk("store_stalls", 256'(st_cnt), 256'd9);
        chk("store_last_addr", {224'd0, addr_q[7]}, 256'h11C);

        // Load with two wait cycles per beat from a preloaded region.
        for (int i = 0; i < 8; i++) mem_m[32'h200 + 32'(4 * i)] = 32'hA0 + 32'(i);
        run_vec(1'b0, 1'b1, 32'h200, rand256(), 2, 2, -1, -1, st_cnt);
        chk("load_vector", ReadDataM,
            256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
        chk("load_stalls", 256'(st_cnt), 256'd25);

        // Both request bits: behaves as a store, load vector untouched.
        snap = ReadDataM;
        run_vec(1'b1, 1'b1, 32'h300, rand256(), 0, 2, -1, -1, st_cnt);
        chk("both_rdata_kept", ReadDataM,
            256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);

        // Address wrap-around.
        run_vec(1'b0, 1'b1, 32'hFFFF_FFF8, rand256(), 0, 1, -1, -1, st_cnt);
        chk("wrap_count", 256'(addr_q.size()), 256'd8);
        for (int i = 0; i < 8; i++) chk("wrap_addr", {224'd0, addr_q[i]}, {224'd0, wrap_exp[i]});

        // Reset during beat 3 of a store, then restart and read it back.
        run_vec(1'b1, 1'b0, 32'h400, rand256(), 0, 1, 3, -1, st_cnt);
        run_vec(1'b0, 1'b1, 32'h400, rand256(), 0, 1, -1, -1, st_cnt);

`ifdef VEC_MEM_TIMEOUT_EN
        // Ack withheld on beat 2: lanes 0-1 fresh, lanes 2-7 keep old data.
        snap = ReadDataM;
        run_vec(1'b0, 1'b1, 32'h200, rand256(), 0, 0, -1, 2, st_cnt);
        chk("timeout_upper_kept", {64'd0, ReadDataM[255:64]}, {64'd0, snap[255:64]});
        chk("timeout_lane1", {224'd0, ReadDataM[63:32]}, 256'hA1);
`endif

        // Randomized traffic over a small region so loads see earlier stores.
        for (int n = 0; n < 40; n++) begin
            bit s;
            bit l;
            s = 1'($urandom);
            l = 1'($urandom);
            if (!s && !l) begin
                MemWriteM  = 1'b0;
                MemtoRegM  = 1'b0;
                ALUResultM = rand256();
                WriteDataM = rand256();
                #1;
                chk("rand_idle_stall", {255'd0, stall_m}, 256'd0);
                @(negedge clk);
                check_quiet("rand_idle");
            end else begin
                run_vec(s, l, 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4,
                        rand256(), 0, 3, -1, -1, st_cnt);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
